// File: rtl/writeback_register_file.sv
// Writeback-stage architectural register file for the 5-stage ARM core.
// Commits the MEM/WB bundle (data write plus optional link write to R14) and
// serves two combinational decode read ports. Each read port bypasses the value
// being committed on the current edge. R15 always reads as pcPlus8 and is never
// written. A write aimed at R15 raises a one-cycle pcWriteAttempt flag instead
// of changing any register. A saturating counter records how many edges
// committed at least one register.
module writeback_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LINK_REG   = 14,
  parameter int PC_REG     = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writebackEnable_WB,
  input  logic                  linkBit_WB,
  input  logic [ADDR_WIDTH-1:0] rd_WB,
  input  logic [DATA_WIDTH-1:0] writeData_WB,
  input  logic [DATA_WIDTH-1:0] linkAddr_WB,
  input  logic [DATA_WIDTH-1:0] pcPlus8,
  input  logic [ADDR_WIDTH-1:0] rn_addr,
  input  logic [ADDR_WIDTH-1:0] rm_addr,
  output logic [DATA_WIDTH-1:0] rn_data,
  output logic [DATA_WIDTH-1:0] rm_data,
  output logic                  pcWriteAttempt,
  output logic [CNT_WIDTH-1:0]  writeCount
);

  localparam int                  NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LINK_IDX = ADDR_WIDTH'(LINK_REG);
  localparam logic [ADDR_WIDTH-1:0] PC_IDX   = ADDR_WIDTH'(PC_REG);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  pc_attempt_q, pc_attempt_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  // Qualified write strobes shared by the commit path and the bypass path, so
  // a bypassed value is always exactly what the edge will commit.
  logic data_wr;      // data write that will actually land in the file
  logic link_wr;      // link write to R14
  logic bypass_ok;    // bypass is suppressed while reset is held

  // Decode the writeback bundle into the writes this edge will perform.
  always_comb begin
    link_wr   = linkBit_WB;
    // The link write owns R14, so a data write to R14 in the same edge drops.
    data_wr   = writebackEnable_WB && (rd_WB != PC_IDX) &&
                !(linkBit_WB && (rd_WB == LINK_IDX));
    bypass_ok = reset;
  end

  // Next register file contents, PC-write flag and saturating commit counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    regs_d       = regs_q;
    pc_attempt_d = writebackEnable_WB && (rd_WB == PC_IDX);
    count_d      = count_q;

    if (data_wr) begin
      regs_d[rd_WB] = writeData_WB;
    end
    if (link_wr) begin
      regs_d[LINK_IDX] = linkAddr_WB;
    end

    // Dual writes on one edge count once; PC-only attempts do not count.
    if ((data_wr || link_wr) && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the register array is architecturally cleared on reset, so it
      // is built from resettable flops rather than an unreset RAM macro.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pc_attempt_q <= 1'b0;
      count_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples its pre-edge input regardless of statement order.
      regs_q       <= regs_d;
      pc_attempt_q <= pc_attempt_d;
      count_q      <= count_d;
    end
  end

  // Read port A: PC, then link bypass, then data bypass, then stored value.
  always_comb begin
    rn_data = regs_q[rn_addr];
    if (rn_addr == PC_IDX) begin
      rn_data = pcPlus8;
    end else if (bypass_ok && link_wr && (rn_addr == LINK_IDX)) begin
      rn_data = linkAddr_WB;
    end else if (bypass_ok && data_wr && (rn_addr == rd_WB)) begin
      rn_data = writeData_WB;
    end
  end

  // Read port B: same priority as port A, fully independent.
  always_comb begin
    rm_data = regs_q[rm_addr];
    if (rm_addr == PC_IDX) begin
      rm_data = pcPlus8;
    end else if (bypass_ok && link_wr && (rm_addr == LINK_IDX)) begin
      rm_data = linkAddr_WB;
    end else if (bypass_ok && data_wr && (rm_addr == rd_WB)) begin
      rm_data = writeData_WB;
    end
  end

  assign pcWriteAttempt = pc_attempt_q;
  assign writeCount     = count_q;

endmodule

// File: tb/tb_writeback_register_file.sv
// Directed bench for writeback_register_file: a vector table of single-edge
// transactions, plus hand sequences for asynchronous reset and counter
// saturation on a narrow-counter instance.
module tb_writeback_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en;
  logic        link;
  logic [3:0]  rd;
  logic [31:0] wdata;
  logic [31:0] laddr;
  logic [31:0] pc8;
  logic [3:0]  rn_addr;
  logic [3:0]  rm_addr;
  logic [31:0] rn_data, rm_data;
  logic        pcwa;
  logic [15:0] wcnt;
  logic [31:0] rn_data_s, rm_data_s;
  logic        pcwa_s;
  logic [3:0]  wcnt_s;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  writeback_register_file dut (
    .clk(clk), .reset(reset),
    .writebackEnable_WB(wb_en), .linkBit_WB(link), .rd_WB(rd),
    .writeData_WB(wdata), .linkAddr_WB(laddr), .pcPlus8(pc8),
    .rn_addr(rn_addr), .rm_addr(rm_addr),
    .rn_data(rn_data), .rm_data(rm_data),
    .pcWriteAttempt(pcwa), .writeCount(wcnt)
  );

  writeback_register_file #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset),
    .writebackEnable_WB(wb_en), .linkBit_WB(link), .rd_WB(rd),
    .writeData_WB(wdata), .linkAddr_WB(laddr), .pcPlus8(pc8),
    .rn_addr(rn_addr), .rm_addr(rm_addr),
    .rn_data(rn_data_s), .rm_data(rm_data_s),
    .pcWriteAttempt(pcwa_s), .writeCount(wcnt_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        wb;
    logic        lk;
    logic [3:0]  rd;
    logic [31:0] wdata;
    logic [31:0] laddr;
    logic [31:0] pc8;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [31:0] rn_pre;
    logic [31:0] rm_pre;
    logic [31:0] rn_post;
    logic [31:0] rm_post;
    logic        pcwa;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // wb  lk  rd  wdata         laddr      pc8        rn  rm  rn_pre        rm_pre        rn_post       rm_post       pcwa cnt
    vecs[0] = '{1'b1, 1'b0, 4'd5,  32'h12345678, 32'h0,     32'h0,    4'd5,  4'd0,  32'h12345678, 32'h0,        32'h12345678, 32'h0,        1'b0, 16'd1};
    vecs[1] = '{1'b1, 1'b1, 4'd2,  32'h0000000A, 32'h100,   32'h0,    4'd2,  4'd14, 32'h0000000A, 32'h100,      32'h0000000A, 32'h100,      1'b0, 16'd2};
    vecs[2] = '{1'b1, 1'b1, 4'd14, 32'h00000BAD, 32'h200,   32'h0,    4'd14, 4'd14, 32'h200,      32'h200,      32'h200,      32'h200,      1'b0, 16'd3};
    vecs[3] = '{1'b1, 1'b0, 4'd15, 32'h00000055, 32'h0,     32'h1008, 4'd15, 4'd5,  32'h1008,     32'h12345678, 32'h1008,     32'h12345678, 1'b1, 16'd3};
    vecs[4] = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h0,     32'h1008, 4'd2,  4'd14, 32'h0000000A, 32'h200,      32'h0000000A, 32'h200,      1'b0, 16'd3};
    vecs[5] = '{1'b1, 1'b0, 4'd0,  32'hCAFEF00D, 32'h0,     32'h2000, 4'd0,  4'd15, 32'hCAFEF00D, 32'h2000,     32'hCAFEF00D, 32'h2000,     1'b0, 16'd4};
    vecs[6] = '{1'b0, 1'b1, 4'd0,  32'h0,        32'h300,   32'h0,    4'd14, 4'd2,  32'h300,      32'h0000000A, 32'h300,      32'h0000000A, 1'b0, 16'd5};
    vecs[7] = '{1'b1, 1'b0, 4'd3,  32'hDEADBEEF, 32'h0,     32'h0,    4'd3,  4'd0,  32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 16'd6};

    reset = 1'b0; wb_en = 1'b0; link = 1'b0; rd = '0; wdata = '0;
    laddr = '0; pc8 = 32'h8; rn_addr = 4'd0; rm_addr = 4'd15;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rn0", rn_data, 32'h0);
    check("reset_rm_pc", rm_data, 32'h8);
    check("reset_cnt", {16'h0, wcnt}, 32'h0);
    check("reset_pcwa", {31'h0, pcwa}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      wb_en = vecs[i].wb; link = vecs[i].lk; rd = vecs[i].rd;
      wdata = vecs[i].wdata; laddr = vecs[i].laddr; pc8 = vecs[i].pc8;
      rn_addr = vecs[i].rn; rm_addr = vecs[i].rm;
      #1;
      check($sformatf("v%0d_rn_pre", i), rn_data, vecs[i].rn_pre);
      check($sformatf("v%0d_rm_pre", i), rm_data, vecs[i].rm_pre);
      @(posedge clk);
      #1;
      wb_en = 1'b0; link = 1'b0;
      #1;
      check($sformatf("v%0d_rn_post", i), rn_data, vecs[i].rn_post);
      check($sformatf("v%0d_rm_post", i), rm_data, vecs[i].rm_post);
      check($sformatf("v%0d_pcwa", i), {31'h0, pcwa}, {31'h0, vecs[i].pcwa});
      check($sformatf("v%0d_cnt", i), {16'h0, wcnt}, {16'h0, vecs[i].cnt});
    end

    // PC write attempt immediately before an asynchronous reset mid-cycle.
    wb_en = 1'b1; rd = 4'd15; wdata = 32'h55; pc8 = 32'h4000;
    @(posedge clk);
    #1;
    check("pre_reset_pcwa", {31'h0, pcwa}, 32'h1);
    wb_en = 1'b1; rd = 4'd3; wdata = 32'h77; rn_addr = 4'd3; rm_addr = 4'd15;
    #2;
    reset = 1'b0;
    #1;
    check("async_rn3", rn_data, 32'h0);
    check("async_rm_pc", rm_data, 32'h4000);
    check("async_cnt", {16'h0, wcnt}, 32'h0);
    check("async_pcwa", {31'h0, pcwa}, 32'h0);
    wb_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_r3", rn_data, 32'h0);

    // Saturation: 20 consecutive writes on both counter widths.
    rn_addr = 4'd1;
    for (int i = 1; i <= 20; i++) begin
      wb_en = 1'b1; rd = 4'd1; wdata = 32'(i);
      @(posedge clk);
      #1;
      if (i == 14) check("sat_cnt_14", {28'h0, wcnt_s}, 32'd14);
      if (i == 15) check("sat_cnt_15", {28'h0, wcnt_s}, 32'd15);
    end
    wb_en = 1'b0;
    #1;
    check("sat_cnt_hold", {28'h0, wcnt_s}, 32'd15);
    check("wide_cnt_20", {16'h0, wcnt}, 32'd20);
    check("sat_r1_last", rn_data_s, 32'd20);
    @(posedge clk);
    #1;
    check("sat_cnt_idle", {28'h0, wcnt_s}, 32'd15);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
